// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for load_store_unit.
// slave is the unit's view; master is the requester/memory environment.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-request load/store unit: byte/half/word accesses with little-endian lanes,
// sub-word stores by read-modify-write against a combinational-read word memory.
module load_store_unit #(
  parameter int unsigned DEPTH_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        ready_en_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] merged_q;

  logic        accept;
  logic        req_bad;
  logic [31:0] load_ext;
  logic [31:0] merge_word;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    req_bad = 1'b0;
    if (bus.req_size == 2'b11)                                   req_bad = 1'b1;
    if (bus.req_size == 2'b01 && bus.req_addr[0])                req_bad = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)     req_bad = 1'b1;
    if ({2'b00, bus.req_addr[31:2]} >= DEPTH_WORDS)              req_bad = 1'b1;
  end

  // Lane extraction and sign/zero extension of the addressed load data.
  always_comb begin
    lane_b   = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_ext = bus.mem_rdata;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = uns_q ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    merge_word = bus.mem_rdata;
    if (size_q == 2'b00)
      merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merge_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      merged_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= req_bad;
        rdata_q <= '0;
      end
      if (state_q == LOAD)  rdata_q  <= load_ext;
      if (state_q == MERGE) merged_q <= merge_word;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = ready_en_q;
        if (bus.req_valid && ready_en_q) begin
          if (req_bad)                  state_d = RESP;
          else if (!bus.req_we)         state_d = LOAD;
          else if (bus.req_size == 2'b10) state_d = WRITE;
          else                          state_d = MERGE;
        end
      end
      LOAD: begin
        bus.mem_addr = {2'b00, addr_q[31:2]};
        state_d      = RESP;
      end
      MERGE: begin
        bus.mem_addr = {2'b00, addr_q[31:2]};
        state_d      = WRITE;
      end
      WRITE: begin
        bus.mem_addr  = {2'b00, addr_q[31:2]};
        bus.mem_we    = 1'b1;
        bus.mem_wdata = (size_q == 2'b10) ? wdata_q : merged_q;
        state_d       = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = (we_q || err_q) ? '0 : rdata_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized requests against a word-array model.
module tb_load_store_unit;
  localparam int unsigned DEPTH = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int resp_cnt = 0;
  logic [31:0] last_waddr, last_wdata;

  assign bus.mem_rdata = mem[bus.mem_addr[6:0]];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      we_cnt++;
      last_waddr = bus.mem_addr;
      last_wdata = bus.mem_wdata;
      mem[bus.mem_addr[6:0]] <= bus.mem_wdata;
    end
    if (bus.resp_valid) resp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rvalid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_rerr"}, 32'(bus.resp_err), 32'd0);
    check({tag, "_rdata"}, bus.resp_rdata, 32'd0);
    check({tag, "_mwe"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_mwdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_maddr"}, bus.mem_addr, 32'd0);
  endtask

  task automatic scramble_req();
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
  endtask

  // Model: expected result computed from the access rules with masks and shifts.
  task automatic do_txn(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    logic        exp_err;
    logic [31:0] exp_rdata, old_w, mask, lane, sign, new_w;
    int          exp_lat, lat, idx, sh, we0;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'd0) || ((addr >> 2) >= DEPTH);
    idx = int'(addr >> 2) % DEPTH;
    sh  = (size == 2'd1) ? 16 * int'(addr[1]) : 8 * int'(addr[1:0]);
    mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sign = (size == 2'd0) ? 32'h80 : 32'h8000;
    old_w = ref_mem[idx];
    exp_rdata = 32'd0;
    new_w = old_w;
    if (exp_err) exp_lat = 1;
    else if (!we) begin
      exp_lat = 2;
      lane = (old_w >> sh) & mask;
      if (size == 2'd2 || uns) exp_rdata = lane;
      else exp_rdata = (lane ^ sign) - sign;
    end else begin
      exp_lat = (size == 2'd2) ? 2 : 3;
      new_w = (old_w & ~(mask << sh)) | ((wdata & mask) << sh);
      ref_mem[idx] = new_w;
    end

    @(negedge clk);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    we0 = we_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    scramble_req();
    check({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_seen"}, 32'(bus.resp_valid), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, "_nwe"}, 32'(we_cnt - we0), (we && !exp_err) ? 32'd1 : 32'd0);
    if (we && !exp_err) begin
      check({tag, "_waddr"}, last_waddr, 32'(idx));
      check({tag, "_wdata"}, last_wdata, new_w);
    end
    @(posedge clk);
    #1;
    check({tag, "_mem"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int r0, w0;
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    bus.req_valid = 1'b0;
    scramble_req();
    #1;
    check_all_zero("por");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("por_rel_ready", 32'(bus.req_ready), 32'd1);

    // Reset pulse while idle
    @(negedge clk); #2;
    reset = 1'b1; #1;
    check_all_zero("rst_idle");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_idle_ready", 32'(bus.req_ready), 32'd1);

    do_txn("st_word", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    mem[4] = 32'h11223344; ref_mem[4] = 32'h11223344;
    do_txn("st_byte", 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5);
    check("st_byte_val", mem[4], 32'hA5223344);
    do_txn("ld_sb", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    do_txn("ld_ub", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    do_txn("ld_sh", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    do_txn("ld_w", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_txn("e_mis_w", 1'b1, 2'd2, 1'b0, 32'h0E, 32'h12345678);
    do_txn("e_mis_h", 1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    do_txn("e_size", 1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF);
    do_txn("e_range", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    do_txn("last_word", 1'b1, 2'd1, 1'b0, 32'h1FE, 32'h0000BEEF);

    // Reset during MERGE of a byte store
    w0 = we_cnt; r0 = resp_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h12; bus.req_wdata = 32'h77;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1; #1;
    check_all_zero("rst_merge");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_merge_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    check("rst_merge_nwe", 32'(we_cnt - w0), 32'd0);
    check("rst_merge_nresp", 32'(resp_cnt - r0), 32'd0);
    check("rst_merge_mem", mem[4], ref_mem[4]);

    for (int n = 0; n < 80; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(128, 300)) << 2
                                      : 32'($urandom_range(0, DEPTH - 1)) << 2;
      a[1:0] = 2'($urandom);
      do_txn("rnd", 1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: DEPTH_WORDS, 128, number of 32-bit words in the downstream data memory (legal word index 0..DEPTH_WORDS-1).
REQ-002 SHALL have ports, one clock, asynchronous active-high reset:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data
- resp_err  output  1  request rejected, valid with resp_valid
- mem_addr  output  32  word index to data memory
- mem_wdata  output  32  full word to write
- mem_we  output  1  write strobe to data memory
- mem_rdata  input  32  combinational read data for mem_addr

Function
REQ-003 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1; req_ready SHALL be 1 only in state IDLE.
REQ-004 SHALL implement states IDLE, LOAD, MERGE, WRITE, RESP.
REQ-005 In IDLE on acceptance SHALL latch all req_* fields and go to RESP with error if any hold: req_size=11; size 01 with addr[0]=1; size 10 with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS.
REQ-006 Otherwise SHALL go to LOAD (req_we=0), WRITE (store, size 10) or MERGE (store, size 00/01).
REQ-007 mem_addr SHALL be {2'b00, latched addr[31:2]} in LOAD, MERGE, WRITE, and 0 otherwise.
REQ-008 LOAD: SHALL extract the addressed lane from mem_rdata, extend it per req_unsigned (word unchanged), register it, then go to RESP.
REQ-009 Lanes SHALL be little-endian: byte n = bits [8n+7:8n] with n=addr[1:0]; half h = bits [16h+15:16h] with h=addr[1].
REQ-010 MERGE: SHALL register mem_rdata with only the addressed lane replaced by the low bits of req_wdata, then go to WRITE.
REQ-011 WRITE: mem_we SHALL be 1 for exactly this one cycle, with mem_wdata = merged word (sub-word) or req_wdata (word); then go to RESP.
REQ-012 mem_we SHALL be 0 and mem_wdata SHALL be 0 in every state except WRITE.
REQ-013 RESP: resp_valid SHALL be 1 for one cycle, then go to IDLE.
REQ-014 In RESP, resp_rdata SHALL hold load data for a successful load and 0 for stores and errors; resp_err SHALL be 1 only for a REQ-005 rejection.
REQ-015 Latency from the acceptance edge to the resp_valid cycle SHALL be:
- error: 1 cycle
- load: 2 cycles
- word store: 2 cycles
- sub-word store: 3 cycles
REQ-016 A rejected request SHALL never assert mem_we.
REQ-017 req_* inputs outside the acceptance edge SHALL be ignored; the unit has no response backpressure.

Reset
REQ-018 Asserting reset SHALL immediately force state IDLE and drive: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_wdata=0, mem_addr=0.
REQ-019 After reset deasserts, req_ready SHALL be 1 from the first clock onward.
REQ-020 Reset during MERGE or WRITE SHALL abandon the operation with no partial write and no response.

Verification
REQ-021 Reset pulse mid-idle -> all outputs 0 during reset; req_ready=1 after release.
REQ-022 Word store 0xDEADBEEF at 0x10 -> mem_we for one cycle with mem_addr=4, mem_wdata=0xDEADBEEF; resp_valid 2 cycles after acceptance with resp_err=0.
REQ-023 mem[4]=0x11223344, byte store 0x000000A5 at 0x13 -> single write of 0xA5223344 to index 4; resp_valid 3 cycles after acceptance.
REQ-024 Loads with mem[4]=0xA5223344 -> signed byte at 0x13 returns 0xFFFFFFA5; unsigned byte at 0x13 returns 0x000000A5; signed half at 0x12 returns 0xFFFFA522; word at 0x10 returns 0xA5223344.
REQ-025 Error requests -> word store at 0x0E, half load at 0x11, size 11, word load at 0x200 (DEPTH_WORDS=128) each give resp_err=1 one cycle after acceptance and never assert mem_we.
REQ-026 Reset asserted in MERGE of a byte store -> mem_we never asserted, memory unchanged, no resp_valid, req_ready=1 after release.
